// File: rtl/enigma_pkg.sv
// rtl/enigma_pkg.sv - shared Enigma datapath constants, FSM state type and index-width helper
package enigma_pkg;

  localparam int N_ALPHA = 26;
  localparam int ASCII_A = 65;

  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    CHECK = 2'd1,
    RUN   = 2'd2
  } state_e;

  // An alphabet of one or two symbols still needs a one-bit index.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/enigma_refl_checker.sv
// rtl/enigma_refl_checker.sv - walks the reflector table once per commit, builds the inverse table
// and registers a pass/fail verdict one cycle before the FSM acts on it.
module enigma_refl_checker
  import enigma_pkg::*;
#(
  parameter int N_SYM  = N_ALPHA,
  parameter bit STRICT = 1'b1,
  localparam int IDX_W = idx_w(N_SYM)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_i,
  input  logic             active_i,
  input  logic [IDX_W-1:0] tbl_i [N_SYM],
  output logic [IDX_W-1:0] inv_o [N_SYM],
  output logic             done_o,
  output logic             pass_o
);

  logic [IDX_W-1:0] cnt_q;
  logic [N_SYM-1:0] seen_q;
  logic             fail_q;
  logic             done_q;
  logic             pass_q;
  logic [IDX_W-1:0] inv_q [N_SYM];

  logic [IDX_W-1:0] v;
  logic             v_in_rng;
  logic             step;
  logic             last;
  logic             bad;

  always_comb begin
    v        = tbl_i[cnt_q];
    v_in_rng = {1'b0, v} < (IDX_W+1)'(N_SYM);
    step     = active_i && !done_q;
    last     = (cnt_q == IDX_W'(N_SYM - 1));
    bad      = !v_in_rng;
    if (v_in_rng) begin
      if (seen_q[v]) bad = 1'b1;
      if (STRICT && ((v == cnt_q) || (tbl_i[v] != cnt_q))) bad = 1'b1;
    end
  end

  // done_q is a one-cycle strobe; the walk stalls on it until the FSM leaves CHECK.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      seen_q <= '0;
      fail_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      for (int j = 0; j < N_SYM; j++) inv_q[j] <= '0;
    end else if (start_i) begin
      cnt_q  <= '0;
      seen_q <= '0;
      fail_q <= 1'b0;
      done_q <= 1'b0;
    end else if (step) begin
      if (v_in_rng) begin
        seen_q[v] <= 1'b1;
        inv_q[v]  <= cnt_q;
      end
      if (last) begin
        done_q <= 1'b1;
        pass_q <= !(fail_q || bad);
      end else begin
        cnt_q  <= cnt_q + IDX_W'(1);
        fail_q <= fail_q || bad;
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  assign inv_o  = inv_q;
  assign done_o = done_q;
  assign pass_o = pass_q;

endmodule

// File: rtl/enigma_reflector_pipe.sv
// rtl/enigma_reflector_pipe.sv - configurable Enigma reflector: table load/validate FSM and a
// single-register valid/ready translation stage with forward or inverse lookup.
module enigma_reflector_pipe
  import enigma_pkg::*;
#(
  parameter int N_SYM  = N_ALPHA,
  parameter int SYM_W  = 8,
  parameter int BASE   = ASCII_A,
  parameter bit STRICT = 1'b1,
  localparam int IDX_W = idx_w(N_SYM)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_wr_i,
  input  logic [IDX_W-1:0] cfg_idx_i,
  input  logic [IDX_W-1:0] cfg_val_i,
  input  logic             cfg_commit_i,
  output logic             cfg_ok_o,
  output logic             cfg_err_o,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [SYM_W-1:0] in_sym_i,
  input  logic             in_dec_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [SYM_W-1:0] out_sym_o,
  output logic             out_err_o
);

  localparam int EXT_W = SYM_W + 1;

  state_e           state_q, state_d;
  logic             cfg_err_q, cfg_err_d;
  logic [IDX_W-1:0] tbl_q [N_SYM];
  logic [IDX_W-1:0] inv [N_SYM];
  logic             chk_start, chk_done, chk_pass, tbl_we;

  logic             out_valid_q, out_err_q;
  logic [SYM_W-1:0] out_sym_q;
  logic [EXT_W-1:0] k_ext;
  logic [IDX_W-1:0] k, entry;
  logic             sym_oob, in_ready, xfer;

  enigma_refl_checker #(
    .N_SYM  (N_SYM),
    .STRICT (STRICT)
  ) u_checker (
    .clk      (clk),
    .reset_n  (reset_n),
    .start_i  (chk_start),
    .active_i (state_q == CHECK),
    .tbl_i    (tbl_q),
    .inv_o    (inv),
    .done_o   (chk_done),
    .pass_o   (chk_pass)
  );

  // A write always wins over a simultaneous commit; the commit is dropped.
  always_comb begin
    state_d   = state_q;
    cfg_err_d = cfg_err_q;
    chk_start = 1'b0;
    tbl_we    = 1'b0;
    unique case (state_q)
      UNCFG: begin
        if (cfg_wr_i) begin
          tbl_we    = 1'b1;
          cfg_err_d = 1'b0;
        end else if (cfg_commit_i) begin
          state_d   = CHECK;
          cfg_err_d = 1'b0;
          chk_start = 1'b1;
        end
      end
      CHECK: begin
        if (chk_done) begin
          state_d   = chk_pass ? RUN : UNCFG;
          cfg_err_d = !chk_pass;
        end
      end
      RUN: begin
        if (cfg_wr_i) begin
          tbl_we    = 1'b1;
          state_d   = UNCFG;
          cfg_err_d = 1'b0;
        end
      end
      default: state_d = UNCFG;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= UNCFG;
      cfg_err_q <= 1'b0;
      for (int j = 0; j < N_SYM; j++) tbl_q[j] <= '0;
    end else begin
      state_q   <= state_d;
      cfg_err_q <= cfg_err_d;
      if (tbl_we) tbl_q[cfg_idx_i] <= cfg_val_i;
    end
  end

  // A symbol below BASE wraps to a huge k_ext, so one unsigned compare covers both ends.
  always_comb begin
    k_ext    = EXT_W'(in_sym_i) - EXT_W'(BASE);
    sym_oob  = (k_ext >= EXT_W'(N_SYM));
    k        = k_ext[IDX_W-1:0];
    entry    = in_dec_i ? inv[k] : tbl_q[k];
    in_ready = (state_q == RUN) && (!out_valid_q || out_ready_i);
    xfer     = in_valid_i && in_ready;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_sym_q   <= '0;
      out_err_q   <= 1'b0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_err_q   <= sym_oob;
      out_sym_q   <= sym_oob ? in_sym_i : SYM_W'(EXT_W'(BASE) + EXT_W'(entry));
    end else if (out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  assign cfg_ok_o    = (state_q == RUN);
  assign cfg_err_o   = cfg_err_q;
  assign in_ready_o  = in_ready;
  assign out_valid_o = out_valid_q;
  assign out_sym_o   = out_sym_q;
  assign out_err_o   = out_err_q;

endmodule
